fp_conv_sched: RTL and testbench

Round-robin scheduler that time-shares one `fp_convert` instance (12-bit two's complement to sign/3-bit exponent/4-bit significand) among `NREQ` sample producers. Each producer offers samples over a valid/ready handshake. The block registers the winning sample, drives it through the shared converter, and presents the tagged result on a single valid/ready output port. It sits between the sample sources and the display/encoding logic that consumes `(S,E,F)`.

---
 rtl/fp_pkg.sv | 15 +
 rtl/fp_convert.sv | 61 ++++++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/fp_conv_sched.sv | 102 ++++++++++
 tb/tb_fp_conv_sched.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared widths and the converted-sample record for the sample-to-float path.
package fp_pkg;

    localparam int SAMPLE_W = 12;
    localparam int EXP_W    = 3;
    localparam int SIG_W    = 4;

    // Converted result: sign, exponent, significand (value = f << e).
    typedef struct packed {
        logic             s;
        logic [EXP_W-1:0] e;
        logic [SIG_W-1:0] f;
    } fp_t;

endpackage

// File: rtl/fp_convert.sv
// Combinational 12-bit two's complement to sign/3-bit exponent/4-bit
// significand converter with round-half-up and saturation.
import fp_pkg::*;

module fp_convert (
    input  logic [SAMPLE_W-1:0] din,
    output fp_t                 res
);

    logic [SAMPLE_W-1:0] mag;
    logic [3:0]          msb;
    logic [SAMPLE_W-1:0] shift_r;
    logic [SIG_W-1:0]    f_raw;
    logic                rnd;
    logic [EXP_W-1:0]    e_raw;

    // Magnitude; 12'h800 stays 12'h800 and is caught by the saturation path.
    assign mag = din[SAMPLE_W-1] ? (~din + 1'b1) : din;

    // Position of the leading one in the magnitude.
    always_comb begin
        // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
        msb = '0;
        for (int i = 0; i < SAMPLE_W; i++) begin
            if (mag[i]) msb = 4'(i);
        end
    end

    // Window of four bits at the leading one plus the rounding bit below it.
    assign shift_r = mag >> (msb - 4'd4);
    assign rnd     = shift_r[0];
    assign f_raw   = shift_r[4:1];
    assign e_raw   = 3'(msb - 4'd3);

    // Exponent/significand selection with rounding carry and saturation.
    always_comb begin
        res.s = din[SAMPLE_W-1];
        res.e = '0;
        res.f = '0;
        if (mag[SAMPLE_W-1]) begin
            res.e = 3'd7;
            res.f = 4'hF;
        end else if (msb < 4'd4) begin
            res.e = '0;
            res.f = mag[SIG_W-1:0];
        end else if (!rnd) begin
            res.e = e_raw;
            res.f = f_raw;
        end else if (f_raw != 4'hF) begin
            res.e = e_raw;
            res.f = f_raw + 4'd1;
        end else if (e_raw == 3'd7) begin
            res.e = 3'd7;
            res.f = 4'hF;
        end else begin
            res.e = e_raw + 3'd1;
            res.f = 4'b1000;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the last winner + 1.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    logic [IDW-1:0] last;
    logic           found;
    int             idx;

    // Priority search starting just after the previous winner, with wrap.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && en && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
            end
        end
    end

    // Pointer follows each transfer; reset value gives requester 0 first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            last <= IDW'(NREQ - 1);
        end else if (|gnt) begin
            last <= gnt_id;
        end
    end

endmodule

// File: rtl/fp_conv_sched.sv
// Round-robin scheduler sharing one fp_convert among NREQ sample producers,
// with a capture stage and a result stage on valid/ready handshakes.
import fp_pkg::*;

module fp_conv_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [SAMPLE_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDW-1:0]           out_id,
    output logic                     out_s,
    output logic [EXP_W-1:0]         out_e,
    output logic [SIG_W-1:0]         out_f
);

    logic                run;
    logic                a_vld;
    logic [IDW-1:0]      a_id;
    logic [SAMPLE_W-1:0] a_data;
    logic                a_adv;
    logic                b_adv;
    logic [NREQ-1:0]     gnt;
    logic [IDW-1:0]      gnt_id;
    logic                xfer;
    logic [SAMPLE_W-1:0] sel_data;
    fp_t                 conv;
    fp_t                 out_res;

    assign b_adv = !out_valid || out_ready;
    assign a_adv = !a_vld || b_adv;

    // Grants are suppressed in reset and on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .en     (a_adv && run),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;

    // Select the granted requester's sample.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) sel_data = req_data[i*SAMPLE_W +: SAMPLE_W];
        end
    end

    // Stage A: capture the winning sample, or bubble when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: data registers are reset too, so no stale sample survives an in-flight reset.
        if (!rst_n) begin
            a_vld  <= 1'b0;
            a_id   <= '0;
            a_data <= '0;
        end else if (a_adv) begin
            a_vld <= xfer;
            if (xfer) begin
                a_id   <= gnt_id;
                a_data <= sel_data;
            end
        end
    end

    fp_convert u_conv (
        .din (a_data),
        .res (conv)
    );

    // Stage B: load the converted result unless the consumer is stalling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_id    <= '0;
            out_res   <= '0;
        end else if (b_adv) begin
            out_valid <= a_vld;
            out_id    <= a_id;
            out_res   <= conv;
        end
    end

    assign out_s = out_res.s;
    assign out_e = out_res.e;
    assign out_f = out_res.f;

endmodule

// File: tb/tb_fp_conv_sched.sv
// Self-checking bench for fp_conv_sched: directed cases with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_fp_conv_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [12*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [IDW-1:0]    out_id;
    logic              out_s;
    logic [2:0]        out_e;
    logic [3:0]        out_f;

    fp_conv_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_s     (out_s),
        .out_e     (out_e),
        .out_f     (out_f)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference conversion from plain integer arithmetic: value ~= f * 2^e.
    function automatic logic [7:0] model_conv(input logic [11:0] x);
        int v, mag, k, e, f;
        v   = int'($signed(x));
        mag = (v < 0) ? -v : v;
        if (mag < 16) begin
            e = 0;
            f = mag;
        end else begin
            k = 0;
            while ((mag >> (k + 1)) != 0) k++;
            e = k - 3;
            f = (mag + (1 << (e - 1))) >> e;
            if (f == 16) begin
                e = e + 1;
                f = 8;
            end
            if (e > 7) begin
                e = 7;
                f = 15;
            end
        end
        return {x[11], 3'(e), 4'(f)};
    endfunction

    typedef struct {
        int         id;
        logic [7:0] r;
        int         t;
    } item_t;

    item_t mq[$];
    int    m_last;
    int    m_cyc;
    bit    chk_en = 1'b0;

    task automatic model_reset();
        mq.delete();
        m_last = NREQ - 1;
        m_cyc  = 0;
    endtask

    // Transaction-level model: at most two samples in flight, in-order delivery,
    // each result visible two cycles after its acceptance.
    always @(negedge clk) begin
        if (chk_en) begin
            bit         adv;
            bit         exp_ov;
            int         g;
            logic [3:0] exp_rdy;
            item_t      it;
            adv     = (mq.size() < 2) || out_ready;
            g       = -1;
            exp_rdy = '0;
            if (adv) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int idx;
                    idx = (m_last + k) % NREQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            exp_ov = (mq.size() > 0) && (mq[0].t <= m_cyc - 2);
            check("out_valid", 32'(out_valid), 32'(exp_ov));
            if (exp_ov && out_valid) begin
                check("out_id", 32'(out_id), 32'(mq[0].id));
                check("out_sef", 32'({out_s, out_e, out_f}), 32'(mq[0].r));
            end
            if (exp_ov && out_ready) void'(mq.pop_front());
            if (g >= 0) begin
                it.id  = g;
                it.r   = model_conv(req_data[g*12 +: 12]);
                it.t   = m_cyc;
                mq.push_back(it);
                m_last = g;
            end
            m_cyc++;
        end
    end

    function automatic logic [11:0] rand_sample();
        logic [11:0] specials [6];
        specials = '{12'h000, 12'hFFF, 12'h800, 12'h7FF, 12'h07C, 12'hF83};
        if ($urandom_range(3) == 0) return specials[$urandom_range(5)];
        return 12'($urandom);
    endfunction

    task automatic rand_data();
        for (int i = 0; i < NREQ; i++) req_data[i*12 +: 12] = rand_sample();
    endtask

    // Release reset away from a clock edge; grants must stay off until after
    // the first rising edge, then the model restarts.
    task automatic do_release();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rdy_first_edge", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        model_reset();
        chk_en = 1'b1;
    endtask

    // One sample through an idle pipeline with a literal expectation.
    task automatic send_one(input int i, input logic [11:0] d,
                            input logic s, input logic [2:0] e, input logic [3:0] f);
        req_valid = '0;
        req_valid[i] = 1'b1;
        req_data[i*12 +: 12] = d;
        @(negedge clk);
        check("dir_rdy", 32'(req_ready[i]), 32'h1);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("dir_ov", 32'(out_valid), 32'h1);
        check("dir_id", 32'(out_id), 32'(i));
        check("dir_sef", 32'({out_s, out_e, out_f}), 32'({s, e, f}));
        @(posedge clk);
        #1;
    endtask

    int cnt [NREQ];
    int acc;

    task automatic run_cycles(input int n, input logic [3:0] vmask, input logic ordy);
        for (int c = 0; c < n; c++) begin
            req_valid = vmask;
            out_ready = ordy;
            rand_data();
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && req_valid[i]) begin
                    cnt[i]++;
                    acc++;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        acc = 0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        req_valid = '1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_id", 32'(out_id), 32'h0);
        check("rst_out_sef", 32'({out_s, out_e, out_f}), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        do_release();
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;

        // Model pins: literal conversions independent of the DUT.
        check("model_07D", 32'(model_conv(12'h07D)), 32'h48);
        check("model_800", 32'(model_conv(12'h800)), 32'hFF);

        // Directed values through the DUT.
        send_one(0, 12'h07D, 1'b0, 3'd4, 4'b1000);
        send_one(1, 12'h000, 1'b0, 3'd0, 4'b0000);
        send_one(1, 12'hFFF, 1'b1, 3'd0, 4'b0001);
        send_one(1, 12'h800, 1'b1, 3'd7, 4'b1111);
        send_one(1, 12'h7FF, 1'b0, 3'd7, 4'b1111);
        send_one(2, 12'h00F, 1'b0, 3'd0, 4'b1111);
        send_one(3, 12'h0F8, 1'b0, 3'd5, 4'b1000);

        // All requesters valid: each granted once every four cycles.
        clear_counts();
        run_cycles(16, 4'hF, 1'b1);
        for (int i = 0; i < NREQ; i++) check("rr_share", 32'(cnt[i]), 32'd4);
        run_cycles(3, 4'h0, 1'b1);

        // Backpressure: only two samples fit while the consumer stalls.
        clear_counts();
        run_cycles(5, 4'hF, 1'b0);
        check("bp_accepted", 32'(acc), 32'd2);
        @(negedge clk);
        check("bp_rdy_zero", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        run_cycles(4, 4'h0, 1'b1);

        // Sparse requesters 1 and 3 alternate; idle ones never granted.
        clear_counts();
        run_cycles(8, 4'b1010, 1'b1);
        check("sp_r0", 32'(cnt[0]), 32'd0);
        check("sp_r1", 32'(cnt[1]), 32'd4);
        check("sp_r2", 32'(cnt[2]), 32'd0);
        check("sp_r3", 32'(cnt[3]), 32'd4);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            req_valid = 4'($urandom);
            out_ready = ($urandom_range(3) != 0);
            rand_data();
            @(posedge clk);
            #1;
        end

        // Reset with both stages full.
        run_cycles(3, 4'hF, 1'b0);
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("mid_rst_ov", 32'(out_valid), 32'h0);
        check("mid_rst_rdy", 32'(req_ready), 32'h0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        do_release();
        @(negedge clk);
        check("post_rst_gnt", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        run_cycles(6, 4'hF, 1'b1);
        run_cycles(4, 4'h0, 1'b1);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
